branch_predict_ctrl: RTL and testbench

Branch prediction and flush sequencer for the 5-stage pipeline. Holds a small direct-mapped BTB with 2-bit saturating counters and gives IF a predicted next PC. Takes resolved branch outcomes from the EX-stage branch compare unit and detects mispredicts. On a mispredict it redirects the PC and drives the IF/ID and ID/EX flush for a fixed number of cycles.

---
 rtl/branch_predict_ctrl_pkg.sv | 37 +++
 rtl/branch_predict_ctrl_btb_table.sv | 78 +++++++
 rtl/branch_predict_ctrl.sv | 159 +++++++++++++++
 tb/tb_branch_predict_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_predict_ctrl_pkg                                       |
// | Description : Shared types and constants for the branch predictor: BTB     |
// |               entry layout, flush sequencer state encoding and 2-bit       |
// |               saturating counter values.                                   |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package branch_predict_ctrl_pkg;

  // Default geometry. The entry struct is sized from these, so any parameter
  // override on the top level has to be mirrored here.
  localparam int BTB_PC_WIDTH   = 16;
  localparam int BTB_INDEX_BITS = 4;
  localparam int BTB_TAG_WIDTH  = BTB_PC_WIDTH - BTB_INDEX_BITS;

  // 2-bit saturating counter values; bit 1 is the taken prediction
  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_WIDTH-1:0] tag;
    logic [BTB_PC_WIDTH-1:0]  target;
    logic [1:0]               ctr;
  } btb_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/branch_predict_ctrl_btb_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_predict_ctrl_btb_table                                 |
// | Description : Direct-mapped BTB storage. Combinational lookup port,        |
// |               synchronous update port with 2-bit saturating counters.      |
// | Ports       : clk, rst          - clock, async active-high reset           |
// |               rd_pc             - lookup PC                                |
// |               rd_hit/rd_taken   - entry hit, counter predicts taken        |
// |               rd_target         - stored target of the looked-up entry     |
// |               wr_en/wr_pc       - apply a resolved branch to the table     |
// |               wr_taken/wr_target- resolved outcome and target              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module branch_predict_ctrl_btb_table
  import branch_predict_ctrl_pkg::*;
#(
  parameter int PC_WIDTH   = BTB_PC_WIDTH,
  parameter int INDEX_BITS = BTB_INDEX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] rd_pc,
  output logic                rd_hit,
  output logic                rd_taken,
  output logic [PC_WIDTH-1:0] rd_target,
  input  logic                wr_en,
  input  logic [PC_WIDTH-1:0] wr_pc,
  input  logic                wr_taken,
  input  logic [PC_WIDTH-1:0] wr_target
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  btb_entry_t r_mem [DEPTH];

  logic [INDEX_BITS-1:0] w_rd_idx;
  logic [INDEX_BITS-1:0] w_wr_idx;
  btb_entry_t            w_rd_entry;
  btb_entry_t            w_wr_entry;
  logic                  w_wr_hit;

  assign w_rd_idx   = rd_pc[INDEX_BITS-1:0];
  assign w_wr_idx   = wr_pc[INDEX_BITS-1:0];
  assign w_rd_entry = r_mem[w_rd_idx];
  assign w_wr_entry = r_mem[w_wr_idx];

  // Reads see the array before this cycle's write lands.
  assign rd_hit    = w_rd_entry.valid && (w_rd_entry.tag == rd_pc[PC_WIDTH-1:INDEX_BITS]);
  assign rd_taken  = w_rd_entry.ctr[1];
  assign rd_target = w_rd_entry.target;

  assign w_wr_hit  = w_wr_entry.valid && (w_wr_entry.tag == wr_pc[PC_WIDTH-1:INDEX_BITS]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (wr_en) begin
      if (wr_taken) begin
        if (w_wr_hit) begin
          r_mem[w_wr_idx].target <= wr_target;
          if (w_wr_entry.ctr != CTR_ST) begin
            r_mem[w_wr_idx].ctr <= w_wr_entry.ctr + 2'd1;
          end
        end else begin
          // Taken miss evicts whatever lived at this index.
          r_mem[w_wr_idx] <= '{valid: 1'b1, tag: wr_pc[PC_WIDTH-1:INDEX_BITS],
                               target: wr_target, ctr: CTR_WT};
        end
      end else if (w_wr_hit && (w_wr_entry.ctr != CTR_SNT)) begin
        r_mem[w_wr_idx].ctr <= w_wr_entry.ctr - 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : branch_predict_ctrl                                          |
// | Description : Branch prediction and flush sequencer. Predicts next PC for  |
// |               IF from the BTB, accepts EX resolves, detects mispredicts,   |
// |               redirects the PC and holds IF/ID + ID/EX flush.              |
// | Ports       : Clk, Reset              - clock, async active-high reset     |
// |               FetchPC -> PredTaken/PredTarget (combinational lookup)       |
// |               Stall                   - freezes sequencer, blocks resolves |
// |               Resolve*                - EX-stage outcome and piped predict |
// |               Redirect/RedirectPC     - registered PC override pulse       |
// |               FlushIFID/FlushIDEX     - registered pipeline flushes        |
// | Option      : BRANCH_PREDICT_STATS_EN adds StatBranches/StatMispredicts    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int PC_WIDTH     = BTB_PC_WIDTH,
  parameter int INDEX_BITS   = BTB_INDEX_BITS,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [PC_WIDTH-1:0] FetchPC,
  output logic                PredTaken,
  output logic [PC_WIDTH-1:0] PredTarget,
  input  logic                Stall,
  input  logic                ResolveValid,
  input  logic [PC_WIDTH-1:0] ResolvePC,
  input  logic                ResolveTaken,
  input  logic [PC_WIDTH-1:0] ResolveTarget,
  input  logic                ResolvePredTaken,
  input  logic [PC_WIDTH-1:0] ResolvePredTarget,
  output logic                Redirect,
  output logic [PC_WIDTH-1:0] RedirectPC,
  output logic                FlushIFID,
`ifdef BRANCH_PREDICT_STATS_EN
  output logic [15:0]         StatBranches,
  output logic [15:0]         StatMispredicts,
`endif
  output logic                FlushIDEX
);

  localparam logic [2:0] C_FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  fsm_state_t            r_state;
  logic [2:0]            r_count;
  logic                  r_last_valid;
  logic [PC_WIDTH-1:0]   r_last_pc;

  logic                  w_hit;
  logic                  w_ctr_taken;
  logic [PC_WIDTH-1:0]   w_btb_target;
  logic                  w_dup;
  logic                  w_accept;
  logic                  w_mispredict;

  branch_predict_ctrl_btb_table #(
    .PC_WIDTH   (PC_WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) u_btb (
    .clk       (Clk),
    .rst       (Reset),
    .rd_pc     (FetchPC),
    .rd_hit    (w_hit),
    .rd_taken  (w_ctr_taken),
    .rd_target (w_btb_target),
    .wr_en     (w_accept),
    .wr_pc     (ResolvePC),
    .wr_taken  (ResolveTaken),
    .wr_target (ResolveTarget)
  );

  assign PredTaken  = w_hit && w_ctr_taken;
  assign PredTarget = w_hit ? w_btb_target : FetchPC + PC_WIDTH'(1);

  // EX can present the same branch twice back-to-back (e.g. held by a
  // hazard); only the first presentation trains the table.
  assign w_dup        = r_last_valid && (r_last_pc == ResolvePC);
  assign w_accept     = ResolveValid && !Stall && (r_state == ST_IDLE) && !w_dup;
  assign w_mispredict = w_accept &&
                        ((ResolveTaken != ResolvePredTaken) ||
                         (ResolveTaken && (ResolveTarget != ResolvePredTarget)));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_last_valid <= 1'b0;
      r_last_pc    <= '0;
    end else begin
      r_last_valid <= w_accept;
      if (w_accept) begin
        r_last_pc <= ResolvePC;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      Redirect   <= 1'b0;
      RedirectPC <= '0;
      FlushIFID  <= 1'b0;
      FlushIDEX  <= 1'b0;
    end else begin
      // Redirect is a single-cycle pulse regardless of Stall.
      Redirect <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_mispredict) begin
            Redirect   <= 1'b1;
            RedirectPC <= ResolveTaken ? ResolveTarget : ResolvePC + PC_WIDTH'(1);
            FlushIFID  <= 1'b1;
            FlushIDEX  <= 1'b1;
            r_count    <= C_FLUSH_INIT;
            // A single-cycle flush needs no FLUSH state at all.
            r_state    <= (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
          end else begin
            FlushIFID <= 1'b0;
            FlushIDEX <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (!Stall) begin
            if (r_count == 3'd0) begin
              r_state   <= ST_IDLE;
              FlushIFID <= 1'b0;
              FlushIDEX <= 1'b0;
            end else begin
              r_count <= r_count - 3'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BRANCH_PREDICT_STATS_EN
  logic [15:0] r_stat_br;
  logic [15:0] r_stat_mp;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else begin
      if (w_accept)     r_stat_br <= r_stat_br + 16'd1;
      if (w_mispredict) r_stat_mp <= r_stat_mp + 16'd1;
    end
  end

  assign StatBranches    = r_stat_br;
  assign StatMispredicts = r_stat_mp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_branch_predict_ctrl                                       |
// | Description : Self-checking bench for branch_predict_ctrl. Directed        |
// |               scenarios followed by randomized resolves/stalls, all        |
// |               checked against a behavioural BTB + flush-window model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_branch_predict_ctrl;

  localparam int PCW   = 16;
  localparam int DEPTH = 16;
  localparam int FC    = 2;

  logic        clk;
  logic        rst;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        stall;
  logic        rv;
  logic [15:0] rpc;
  logic        rtk;
  logic [15:0] rtgt;
  logic        rptk;
  logic [15:0] rptgt;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        flush_ifid;
  logic        flush_idex;
`ifdef BRANCH_PREDICT_STATS_EN
  logic [15:0] stat_br;
  logic [15:0] stat_mp;
`endif

  branch_predict_ctrl #(
    .PC_WIDTH     (PCW),
    .INDEX_BITS   (4),
    .FLUSH_CYCLES (FC)
  ) dut (
    .Clk               (clk),
    .Reset             (rst),
    .FetchPC           (fetch_pc),
    .PredTaken         (pred_taken),
    .PredTarget        (pred_target),
    .Stall             (stall),
    .ResolveValid      (rv),
    .ResolvePC         (rpc),
    .ResolveTaken      (rtk),
    .ResolveTarget     (rtgt),
    .ResolvePredTaken  (rptk),
    .ResolvePredTarget (rptgt),
    .Redirect          (redirect),
    .RedirectPC        (redirect_pc),
    .FlushIFID         (flush_ifid),
`ifdef BRANCH_PREDICT_STATS_EN
    .StatBranches      (stat_br),
    .StatMispredicts   (stat_mp),
`endif
    .FlushIDEX         (flush_idex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: table indexed by pc % DEPTH, tagged by pc / DEPTH.
  bit          mv   [DEPTH];
  int          mtag [DEPTH];
  logic [15:0] mtgt [DEPTH];
  int          mctr [DEPTH];
  int          flush_left;   // flush cycles still owed, including current one
  bit          exp_redirect;
  logic [15:0] exp_rpc;
  bit          last_valid;
  logic [15:0] last_pc;
  int          n_br;
  int          n_mp;
  logic [15:0] pool [8];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = 1'b0; mtag[i] = 0; mtgt[i] = 16'h0; mctr[i] = 1;
    end
    flush_left = 0; exp_redirect = 1'b0; exp_rpc = 16'h0;
    last_valid = 1'b0; last_pc = 16'h0; n_br = 0; n_mp = 0;
  endtask

  function automatic void model_lookup(input logic [15:0] pc, output logic t, output logic [15:0] tgt);
    int  i = int'(pc) % DEPTH;
    bit  h = mv[i] && (mtag[i] == int'(pc) / DEPTH);
    t   = h && (mctr[i] >= 2);
    tgt = h ? mtgt[i] : pc + 16'd1;
  endfunction

  task automatic check_regs(input string tag);
    check_val({tag, "_redirect"}, 32'(redirect), 32'(exp_redirect));
    check_val({tag, "_redirect_pc"}, 32'(redirect_pc), 32'(exp_rpc));
    check_val({tag, "_flush_ifid"}, 32'(flush_ifid), 32'(flush_left > 0));
    check_val({tag, "_flush_idex"}, 32'(flush_idex), 32'(flush_left > 0));
`ifdef BRANCH_PREDICT_STATS_EN
    check_val({tag, "_stat_br"}, 32'(stat_br), 32'(n_br % 65536));
    check_val({tag, "_stat_mp"}, 32'(stat_mp), 32'(n_mp % 65536));
`endif
  endtask

  // One clock: drive at negedge, check lookup, model the edge, check registers.
  task automatic run_cycle(input logic [15:0] fpc, input logic v, input logic [15:0] pc,
                           input logic tk, input logic [15:0] tg, input logic ptk,
                           input logic [15:0] ptg, input logic st);
    logic        et;
    logic [15:0] eg;
    bit          acc, misp, rhit;
    int          ri;
    @(negedge clk);
    fetch_pc = fpc; rv = v; rpc = pc; rtk = tk; rtgt = tg; rptk = ptk; rptgt = ptg; stall = st;
    #1;
    model_lookup(fpc, et, eg);
    check_val("pred_taken", 32'(pred_taken), 32'(et));
    check_val("pred_target", 32'(pred_target), 32'(eg));
    acc  = v && !st && !((flush_left > 0) && (FC > 1)) && !(last_valid && (last_pc == pc));
    misp = acc && ((tk != ptk) || (tk && (tg != ptg)));
    @(posedge clk);
    if (acc) begin
      ri   = int'(pc) % DEPTH;
      rhit = mv[ri] && (mtag[ri] == int'(pc) / DEPTH);
      if (tk) begin
        if (rhit) begin
          mtgt[ri] = tg;
          mctr[ri] = (mctr[ri] < 3) ? mctr[ri] + 1 : 3;
        end else begin
          mv[ri] = 1'b1; mtag[ri] = int'(pc) / DEPTH; mtgt[ri] = tg; mctr[ri] = 2;
        end
      end else if (rhit && (mctr[ri] > 0)) begin
        mctr[ri] = mctr[ri] - 1;
      end
      n_br++;
    end
    if (misp) begin
      n_mp++;
      flush_left   = FC;
      exp_redirect = 1'b1;
      exp_rpc      = tk ? tg : pc + 16'd1;
    end else begin
      exp_redirect = 1'b0;
      if ((flush_left > 0) && (!st || (FC == 1))) flush_left--;
    end
    last_valid = acc;
    if (acc) last_pc = pc;
    #1;
    check_regs("cyc");
  endtask

  task automatic idle_cycles(input int n, input logic [15:0] fpc);
    for (int k = 0; k < n; k++) run_cycle(fpc, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic        mt;
    logic [15:0] mg;
    logic [15:0] prev_pc;
    logic [15:0] pc_r;
    pool[0] = 16'h0013; pool[1] = 16'h0023; pool[2] = 16'h0040; pool[3] = 16'h0020;
    pool[4] = 16'h0013; pool[5] = 16'hFFFF; pool[6] = 16'h0007; pool[7] = 16'h0017;
    rst = 1'b1; fetch_pc = 16'h0; stall = 1'b0; rv = 1'b0; rpc = 16'h0; rtk = 1'b0;
    rtgt = 16'h0; rptk = 1'b0; rptg_init();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_regs("reset");

    // 1: empty table lookup
    idle_cycles(1, 16'h0013);
    // 2: taken mispredict allocates, redirects to 0x0040, then predicts taken
    run_cycle(16'h0013, 1'b1, 16'h0013, 1'b1, 16'h0040, 1'b0, 16'h0014, 1'b0);
    idle_cycles(3, 16'h0013);
    // 3: two not-taken resolves drive ctr 2 -> 1 -> 0
    run_cycle(16'h0013, 1'b1, 16'h0013, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0);
    idle_cycles(3, 16'h0013);
    run_cycle(16'h0013, 1'b1, 16'h0013, 1'b0, 16'h0000, 1'b0, 16'h0014, 1'b0);
    idle_cycles(1, 16'h0013);
    // 5: duplicate suppression on consecutive identical resolves
    run_cycle(16'h0013, 1'b1, 16'h0013, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0);
    run_cycle(16'h0013, 1'b1, 16'h0013, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0);
    idle_cycles(1, 16'h0013);
    // 4: wrong-path resolve during stalled flush
    run_cycle(16'h0020, 1'b1, 16'h0055, 1'b1, 16'h0100, 1'b0, 16'h0056, 1'b0);
    for (int k = 0; k < 3; k++) run_cycle(16'h0020, 1'b1, 16'h0020, 1'b1, 16'h0080, 1'b0, 16'h0021, 1'b1);
    for (int k = 0; k < 3; k++) run_cycle(16'h0020, 1'b1, 16'h0020, 1'b1, 16'h0080, 1'b0, 16'h0021, 1'b0);
    // wrap of ResolvePC+1
    idle_cycles(1, 16'hFFFF);
    run_cycle(16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0);
    idle_cycles(2, 16'hFFFF);

    // Random phase
    prev_pc = 16'h0013;
    for (int n = 0; n < 500; n++) begin
      pc_r = (($urandom % 4) == 0) ? prev_pc : pool[$urandom % 8];
      model_lookup(pc_r, mt, mg);
      if (($urandom % 4) == 0) begin
        mt = 1'($urandom % 2);
        mg = pool[$urandom % 8];
      end
      run_cycle(pool[$urandom % 8], 1'(($urandom % 10) < 6), pc_r, 1'($urandom % 2),
                pool[$urandom % 8] ^ 16'($urandom % 2), mt, mg, 1'(($urandom % 5) == 0));
      prev_pc = pc_r;
    end

    // 6: async reset mid-flush
    idle_cycles(3, 16'h0013);
    run_cycle(16'h0013, 1'b1, 16'h0033, 1'b1, 16'h0200, 1'b0, 16'h0034, 1'b0);
    @(negedge clk);
    rv = 1'b0;
    rst = 1'b1;
    #1;
    check_val("async_rst_flush_ifid", 32'(flush_ifid), 32'(0));
    check_val("async_rst_flush_idex", 32'(flush_idex), 32'(0));
    check_val("async_rst_redirect", 32'(redirect), 32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2, 16'h0013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic rptg_init();
    rptgt = 16'h0;
  endtask

endmodule
`default_nettype wire
